sample_trigger_ctrl: RTL
========================

# sample_trigger_ctrl

Upstream sampling controller for the per-channel sample shift buffer. It synchronises the raw channel inputs and divides the clock into a sample strobe. It runs a pre-fill / armed / post-trigger state machine, so the downstream buffer (DEPTH samples per channel) freezes holding a trigger-centred capture window. The downstream buffer shifts `sample_out` in only on cycles where `sample_en` is high.

## Interface
Parameters:
- NUM_CHANNELS, 7, number of 1-bit sample channels
- DEPTH, 10, samples held per channel by the downstream buffer
- DIV_WIDTH, 8, width of the prescaler divisor
- CNT_WIDTH, $clog2(DEPTH), width of post_count and internal sample counters

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- sample_in  in  NUM_CHANNELS  raw asynchronous channel inputs
- arm  in  1  single-cycle start/restart pulse
- trig_sel  in  3  channel index used as edge-trigger source; values ≥ NUM_CHANNELS select channel 0
- trig_edge  in  1  1 = rising, 0 = falling
- div  in  DIV_WIDTH  strobe period minus one, in clk cycles
- post_count  in  CNT_WIDTH  samples kept after the trigger sample; clamped to DEPTH-1
- sample_en  out  1  shift strobe to the buffer
- sample_out  out  NUM_CHANNELS  synchronised sample, valid while sample_en is high
- triggered  out  1  level; trigger has fired in the current capture
- capture_done  out  1  level; buffer contents are final
- busy  out  1  high in PRE, ARMED and POST

## Operation
- Input sync: two flops on every sample_in bit, always running.
- States:
  - IDLE (reset state)
  - PRE: pre-fill, P = DEPTH-1-N strobes, where N is the clamped post_count
  - ARMED
  - POST: N strobes
  - DONE
- Transitions:
  - arm → PRE from any state.
  - PRE → ARMED after P strobes. If P = 0, PRE lasts zero strobes and the first strobe is already evaluated as ARMED.
  - ARMED → POST on a strobe whose sample matches the trigger. If N = 0, that strobe goes directly to DONE.
  - POST → DONE on its N-th strobe.
  - DONE holds until arm.
- Prescaler:
  - Counter is cleared on arm.
  - Runs only in PRE/ARMED/POST.
  - Strobe fires when counter == div, then counter returns to 0.
  - div = 0 gives a strobe every cycle.
- On each strobe, sample_out is loaded from the sync output and sample_en pulses for one cycle. The two are registered together.
- Edge detect: compare the trigger channel in the current strobed sample against the previous strobed sample.
  - The previous-sample register is loaded from the sync output on arm.
  - A level already present at arm never triggers.
- Counters, trig_sel, trig_edge, div and post_count are latched at arm. Changes during a capture are ignored.
- arm mid-capture restarts cleanly: counters cleared, triggered cleared, no residual strobe.
- Buffer contract: at DONE the buffer holds exactly P pre-trigger samples + 1 trigger sample + N post samples, plus older samples if ARMED waited.

## Timing
- Reset values: sample_en = 0, sample_out = 0, triggered = 0, capture_done = 0, busy = 0, state IDLE, all counters 0.
- sample_in to sync output latency is 2 cycles.
- First sample_en is high div+1 cycles after the edge that samples arm. Later strobes follow every div+1 cycles.
- triggered rises in the same cycle as the trigger strobe's sample_en.
- capture_done rises in the same cycle as the final sample_en. No further sample_en occurs until the next arm.
- busy falls in that same cycle.
- reset has priority over arm. arm during reset is ignored.

## Configuration
- PATTERN_TRIGGER_EN defined:
  - Adds ports trig_mode (in, 1), pattern (in, NUM_CHANNELS) and mask (in, NUM_CHANNELS), all latched at arm.
  - trig_mode = 1: the trigger condition is (sample & mask) == (pattern & mask) on a strobe.
  - trig_mode = 1 with mask = 0 triggers on the first ARMED strobe.
  - trig_mode = 0: edge trigger.
- Undefined: these ports are absent and the block uses edge trigger only.

## Test plan
- Reset with sample_in = 7'h7F → every output 0 and busy = 0, for 20 cycles with no arm.
- div = 3, post_count = 4, arm, ch2 rises at the 12th strobe → sample_en every 4 cycles, 5 PRE strobes, triggered on strobe 12, capture_done on strobe 16, then sample_en stays 0.
- div = 0, post_count = 0, trig_edge = 0, ch0 held high at arm and then falls → no trigger before the fall; DONE on the strobe that samples the fall.
- post_count = 15 (DEPTH = 10) → clamped to 9: P = 0, exactly 9 strobes after the trigger.
- Re-arm during POST after 2 post strobes → triggered clears, the PRE count restarts from 0, and no extra sample_en appears in the arm cycle.
- PATTERN_TRIGGER_EN, mask = 7'h05, pattern = 7'h05, sample_in = 7'h27 → triggers on the first ARMED strobe.

Source files
------------

// File: rtl/sample_trigger_ctrl.sv
// ---------------------------------------------------------------------------
// sample_trigger_ctrl
//
// Upstream sampling controller for a per-channel sample shift buffer.
// Synchronises the raw channel inputs, divides the clock into a sample
// strobe and runs a pre-fill / armed / post-trigger sequence so that the
// downstream buffer (DEPTH samples per channel) ends up holding a
// trigger-centred capture window.
//
// Optional feature macro: PATTERN_TRIGGER_EN
//   When defined, adds trig_mode / pattern / mask for a masked pattern
//   trigger alongside the edge trigger. When undefined, edge trigger only.
//
// Ports:
//   clk          in   clock
//   reset        in   synchronous, active-high
//   sample_in    in   raw asynchronous channel inputs [NUM_CHANNELS]
//   arm          in   single-cycle start/restart pulse
//   trig_sel     in   edge-trigger channel index (>= NUM_CHANNELS -> ch 0)
//   trig_edge    in   1 = rising, 0 = falling
//   div          in   strobe period minus one, in clk cycles
//   post_count   in   samples kept after the trigger (clamped to DEPTH-1)
//   trig_mode    in   (PATTERN_TRIGGER_EN) 1 = pattern trigger, 0 = edge
//   pattern      in   (PATTERN_TRIGGER_EN) trigger pattern
//   mask         in   (PATTERN_TRIGGER_EN) pattern compare mask
//   sample_en    out  one-cycle shift strobe to the buffer
//   sample_out   out  synchronised sample, valid while sample_en is high
//   triggered    out  trigger has fired in the current capture
//   capture_done out  buffer contents are final
//   busy         out  capture in progress (PRE, ARMED, POST)
// ---------------------------------------------------------------------------
module sample_trigger_ctrl #(
    parameter int NUM_CHANNELS = 7,
    parameter int DEPTH        = 10,
    parameter int DIV_WIDTH    = 8,
    parameter int CNT_WIDTH    = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CHANNELS-1:0] sample_in,
    input  logic                    arm,
    input  logic [2:0]              trig_sel,
    input  logic                    trig_edge,
    input  logic [DIV_WIDTH-1:0]    div,
    input  logic [CNT_WIDTH-1:0]    post_count,
`ifdef PATTERN_TRIGGER_EN
    input  logic                    trig_mode,
    input  logic [NUM_CHANNELS-1:0] pattern,
    input  logic [NUM_CHANNELS-1:0] mask,
`endif
    output logic                    sample_en,
    output logic [NUM_CHANNELS-1:0] sample_out,
    output logic                    triggered,
    output logic                    capture_done,
    output logic                    busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_ARMED = 3'd2,
        S_POST  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [CNT_WIDTH-1:0] DEPTH_M1 = CNT_WIDTH'(DEPTH - 1);

    // Saturate the post-trigger count so pre + trigger + post never exceeds DEPTH.
    function automatic logic [CNT_WIDTH-1:0] clamp_post(input logic [CNT_WIDTH-1:0] n);
        if (n > DEPTH_M1) begin
            return DEPTH_M1;
        end
        return n;
    endfunction

    // Out-of-range channel indices fall back to channel 0.
    function automatic logic [2:0] resolve_sel(input logic [2:0] s);
        if (int'(s) >= NUM_CHANNELS) begin
            return 3'd0;
        end
        return s;
    endfunction

    logic [NUM_CHANNELS-1:0] sync1_q, sync2_q;
    logic [NUM_CHANNELS-1:0] prev_q;
    logic [NUM_CHANNELS-1:0] sample_out_q;
    logic                    sample_en_q;
    logic                    triggered_q;

    state_t                  state_q, state_d;
    logic [DIV_WIDTH-1:0]    presc_q, presc_d;
    logic [CNT_WIDTH-1:0]    smp_cnt_q, smp_cnt_d;

    // Capture configuration, frozen at arm.
    logic [DIV_WIDTH-1:0]    div_q;
    logic [CNT_WIDTH-1:0]    post_q;
    logic [CNT_WIDTH-1:0]    pre_q;
    logic [2:0]              sel_q;
    logic                    edge_q;
`ifdef PATTERN_TRIGGER_EN
    logic                    mode_q;
    logic [NUM_CHANNELS-1:0] pattern_q;
    logic [NUM_CHANNELS-1:0] mask_q;
`endif

    logic [CNT_WIDTH-1:0]    post_clamped;
    logic                    busy_w;
    logic                    strobe;
    logic                    cur_bit, prev_bit;
    logic                    edge_hit;
    logic                    trig_hit;
    logic                    armed_eval;
    logic                    trig_set;

    assign post_clamped = clamp_post(post_count);

    // Two-flop synchroniser, free running.
    always_ff @(posedge clk) begin
        sync1_q <= sample_in;
        sync2_q <= sync1_q;
    end

    assign busy_w = (state_q == S_PRE) || (state_q == S_ARMED) || (state_q == S_POST);
    assign strobe = busy_w && (presc_q == div_q);

    assign cur_bit  = sync2_q[sel_q];
    assign prev_bit = prev_q[sel_q];
    assign edge_hit = edge_q ? (!prev_bit && cur_bit) : (prev_bit && !cur_bit);

`ifdef PATTERN_TRIGGER_EN
    assign trig_hit = mode_q ? ((sync2_q & mask_q) == (pattern_q & mask_q)) : edge_hit;
`else
    assign trig_hit = edge_hit;
`endif

    // With zero pre-fill samples the very first strobe is already a trigger candidate.
    assign armed_eval = (state_q == S_ARMED) || ((state_q == S_PRE) && (pre_q == '0));

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        smp_cnt_d = smp_cnt_q;
        trig_set  = 1'b0;
        if (arm) begin
            state_d   = S_PRE;
            presc_d   = '0;
            smp_cnt_d = '0;
        end else begin
            if (busy_w) begin
                presc_d = strobe ? '0 : presc_q + DIV_WIDTH'(1);
            end
            if (strobe) begin
                if (armed_eval) begin
                    if (trig_hit) begin
                        trig_set  = 1'b1;
                        smp_cnt_d = '0;
                        state_d   = (post_q == '0) ? S_DONE : S_POST;
                    end else begin
                        state_d = S_ARMED;
                    end
                end else begin
                    case (state_q)
                        S_PRE: begin
                            if (smp_cnt_q == pre_q - CNT_WIDTH'(1)) begin
                                state_d   = S_ARMED;
                                smp_cnt_d = '0;
                            end else begin
                                smp_cnt_d = smp_cnt_q + CNT_WIDTH'(1);
                            end
                        end
                        S_POST: begin
                            if (smp_cnt_q == post_q - CNT_WIDTH'(1)) begin
                                state_d = S_DONE;
                            end else begin
                                smp_cnt_d = smp_cnt_q + CNT_WIDTH'(1);
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            presc_q      <= '0;
            smp_cnt_q    <= '0;
            sample_en_q  <= 1'b0;
            sample_out_q <= '0;
            triggered_q  <= 1'b0;
            div_q        <= '0;
            post_q       <= '0;
            pre_q        <= '0;
            sel_q        <= '0;
            edge_q       <= 1'b0;
`ifdef PATTERN_TRIGGER_EN
            mode_q       <= 1'b0;
            pattern_q    <= '0;
            mask_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            smp_cnt_q   <= smp_cnt_d;
            // An arm in a strobe cycle swallows that strobe.
            sample_en_q <= strobe && !arm;
            if (arm) begin
                triggered_q <= 1'b0;
                div_q       <= div;
                post_q      <= post_clamped;
                pre_q       <= DEPTH_M1 - post_clamped;
                sel_q       <= resolve_sel(trig_sel);
                edge_q      <= trig_edge;
`ifdef PATTERN_TRIGGER_EN
                mode_q      <= trig_mode;
                pattern_q   <= pattern;
                mask_q      <= mask;
`endif
            end else begin
                if (strobe) begin
                    sample_out_q <= sync2_q;
                end
                if (trig_set) begin
                    triggered_q <= 1'b1;
                end
            end
        end
    end

    // Edge-detect history; seeded at arm so a level already present never fires.
    always_ff @(posedge clk) begin
        if (arm || strobe) begin
            prev_q <= sync2_q;
        end
    end

    assign sample_en    = sample_en_q;
    assign sample_out   = sample_out_q;
    assign triggered    = triggered_q;
    assign capture_done = (state_q == S_DONE);
    assign busy         = busy_w;

endmodule
